// File: rtl/cpu_pkg.sv
// Shared types and constants for the processor boot path.
// The loader FSM state encoding lives here so that status decoders can reuse it.
package cpu_pkg;

    localparam int INSTR_W        = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: a lane counter plus one byte register per lane.
// word_o bypasses the incoming byte, so the word is complete in the same cycle its last lane arrives.
module byte_packer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               accept_i,
    input  logic [7:0]         data_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               word_done_o
);

    logic [LANE_W-1:0] lane_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            lane_q <= '0;
        end else if (accept_i) begin
            lane_q <= lane_q + 1'b1;
        end
    end

    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        logic [7:0] byte_q;
        logic       hit;

        assign hit = accept_i && (lane_q == LANE_W'(gi));

        always_ff @(posedge clk) begin
            if (reset) begin
                byte_q <= '0;
            end else if (hit) begin
                byte_q <= data_i;
            end
        end

        assign word_o[8*gi +: 8] = hit ? data_i : byte_q;
    end

    assign word_done_o = accept_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory word by word and holds the core
// in reset until a complete, well-formed image has been written.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    input  logic               s_last,
    output logic               imem_wr_en,
    output logic [ADDR_W-1:0]  imem_wr_addr,
    output logic [INSTR_W-1:0] imem_wr_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               err,
    output logic [ADDR_W:0]    words_loaded
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_t      state_q, state_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [ADDR_W:0]    words_q, words_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [INSTR_W-1:0] wr_data_q, wr_data_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               clear;
    logic               accept;
    logic               word_done;
    logic [INSTR_W-1:0] word;

    assign s_ready = (state_q == ST_LOAD);
    assign accept  = s_valid && s_ready;

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .accept_i    (accept),
        .data_i      (s_data),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    clear   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (word_done) begin
                    if (s_last) begin
                        state_d = ST_DONE;
                    end else if (waddr_q == LAST_ADDR) begin
                        state_d = ST_ERROR;
                    end
                end else if (accept && s_last) begin
                    state_d = ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        waddr_d   = waddr_q;
        words_d   = words_q;
        wr_en_d   = word_done;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (clear) begin
            waddr_d = '0;
            words_d = '0;
        end
        if (word_done) begin
            wr_addr_d = waddr_q;
            wr_data_d = word;
            waddr_d   = waddr_q + 1'b1;
            words_d   = words_q + 1'b1;
        end
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERROR);
        // Release the core only after a full cycle in DONE, so the last write lands first.
        hold_d = !((state_q == ST_DONE) && (state_d == ST_DONE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            waddr_q   <= '0;
            words_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            words_q   <= words_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a full-size instance and a DEPTH=4 instance share
// the same stream; each write seen on either is logged and compared against hand-computed values.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;

    logic        s_ready, wr_en, hold, done, err;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [8:0]  words;

    logic        s_ready4, wr_en4, hold4, done4, err4;
    logic [1:0]  wr_addr4;
    logic [31:0] wr_data4;
    logic [2:0]  words4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t wq[$];
    wr_t wq4[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .imem_wr_en(wr_en), .imem_wr_addr(wr_addr),
        .imem_wr_data(wr_data), .cpu_hold(hold), .done(done), .err(err), .words_loaded(words)
    );

    imem_loader #(.ADDR_W(2), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready4),
        .s_data(s_data), .s_last(s_last), .imem_wr_en(wr_en4), .imem_wr_addr(wr_addr4),
        .imem_wr_data(wr_data4), .cpu_hold(hold4), .done(done4), .err(err4), .words_loaded(words4)
    );

    always @(posedge clk) begin
        #1;
        if (wr_en) begin
            wq.push_back('{a: 32'(wr_addr), d: wr_data});
            $display("write   depth256 addr=%0d data=%08h", wr_addr, wr_data);
        end
        if (wr_en4) begin
            wq4.push_back('{a: 32'(wr_addr4), d: wr_data4});
            $display("write   depth4   addr=%0d data=%08h", wr_addr4, wr_data4);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b, input logic last);
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".s_ready"}, 64'(s_ready), 0);
        check({tag, ".wr_en"},   64'(wr_en),   0);
        check({tag, ".addr"},    64'(wr_addr), 0);
        check({tag, ".data"},    64'(wr_data), 0);
        check({tag, ".hold"},    64'(hold),    1);
        check({tag, ".done"},    64'(done),    0);
        check({tag, ".err"},     64'(err),     0);
        check({tag, ".words"},   64'(words),   0);
    endtask

    logic [7:0] img [8];

    initial begin
        img[0] = 8'h13; img[1] = 8'h20; img[2] = 8'h04; img[3] = 8'h00;
        img[4] = 8'h85; img[5] = 8'h40; img[6] = 8'h00; img[7] = 8'h00;
        reset = 1'b1; start = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;

        // Reset with start held: reset must win.
        gap(3);
        check("rst_start.s_ready", 64'(s_ready), 0);
        reset = 1'b0;
        start = 1'b0;
        gap(1);
        check_reset_values("reset");
        check("reset.hold4", 64'(hold4), 1);

        // Basic load
        pulse_start();
        check("basic.s_ready_after_start", 64'(s_ready), 1);
        check("basic.hold_loading", 64'(hold), 1);
        for (int i = 0; i < 4; i++) put(img[i], 1'b0);
        check("basic.w0_strobe", 64'(wr_en), 1);
        check("basic.w0_addr", 64'(wr_addr), 0);
        check("basic.w0_data", 64'(wr_data), 64'h00042013);
        put(img[4], 1'b0);
        check("basic.strobe_one_cycle", 64'(wr_en), 0);
        for (int i = 5; i < 8; i++) put(img[i], i == 7);
        check("basic.w1_strobe", 64'(wr_en), 1);
        check("basic.w1_addr", 64'(wr_addr), 1);
        check("basic.w1_data", 64'(wr_data), 64'h00004085);
        check("basic.done", 64'(done), 1);
        check("basic.hold_with_done", 64'(hold), 1);
        check("basic.words", 64'(words), 2);
        check("basic.s_ready_done", 64'(s_ready), 0);
        gap(1);
        check("basic.hold_released", 64'(hold), 0);
        check("basic.wr_en_low", 64'(wr_en), 0);
        check("basic.addr_held", 64'(wr_addr), 1);
        check("basic.nwrites", 64'(wq.size()), 2);
        check("basic.log0", {wq[0].a, wq[0].d}, {32'd0, 32'h00042013});
        check("basic.log1", {wq[1].a, wq[1].d}, {32'd1, 32'h00004085});
        wq.delete(); wq4.delete();

        // Reload a 1-word image over address 0
        pulse_start();
        check("reload.hold", 64'(hold), 1);
        check("reload.done_clear", 64'(done), 0);
        check("reload.s_ready", 64'(s_ready), 1);
        check("reload.words_clear", 64'(words), 0);
        put(8'hAA, 1'b0); put(8'hBB, 1'b0); put(8'hCC, 1'b0); put(8'hDD, 1'b1);
        check("reload.done", 64'(done), 1);
        check("reload.words", 64'(words), 1);
        check("reload.nwrites", 64'(wq.size()), 1);
        check("reload.log0", {wq[0].a, wq[0].d}, {32'd0, 32'hDDCCBBAA});
        gap(2);
        check("reload.hold_released", 64'(hold), 0);
        wq.delete(); wq4.delete();

        // Stalled input: three idle cycles between bytes
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            put(img[i], i == 7);
            if (i != 7) gap(3);
        end
        check("stall.done", 64'(done), 1);
        check("stall.words", 64'(words), 2);
        gap(2);
        check("stall.nwrites", 64'(wq.size()), 2);
        check("stall.log0", {wq[0].a, wq[0].d}, {32'd0, 32'h00042013});
        check("stall.log1", {wq[1].a, wq[1].d}, {32'd1, 32'h00004085});
        wq.delete(); wq4.delete();

        // Short image: s_last on lane 1 of word 1
        pulse_start();
        for (int i = 0; i < 6; i++) put(img[i], i == 5);
        check("short.err", 64'(err), 1);
        check("short.done", 64'(done), 0);
        check("short.s_ready", 64'(s_ready), 0);
        check("short.words", 64'(words), 1);
        gap(2);
        check("short.hold", 64'(hold), 1);
        check("short.nwrites", 64'(wq.size()), 1);
        check("short.log0", {wq[0].a, wq[0].d}, {32'd0, 32'h00042013});
        wq.delete(); wq4.delete();

        // Reset after byte 2 of word 1
        pulse_start();
        check("midrst.err_clear", 64'(err), 0);
        for (int i = 0; i < 6; i++) put(img[i], 1'b0);
        reset = 1'b1;
        gap(2);
        reset = 1'b0;
        gap(1);
        check("midrst.nwrites", 64'(wq.size()), 1);
        check_reset_values("midrst");
        pulse_start();
        put(8'h11, 1'b0); put(8'h22, 1'b0); put(8'h33, 1'b0); put(8'h44, 1'b1);
        check("midrst.reload_done", 64'(done), 1);
        check("midrst.nwrites_after", 64'(wq.size()), 2);
        check("midrst.fresh_log", {wq[1].a, wq[1].d}, {32'd0, 32'h44332211});
        wq.delete(); wq4.delete();

        // Overflow on the DEPTH=4 instance; full-size instance keeps loading
        reset = 1'b1;
        gap(1);
        reset = 1'b0;
        pulse_start();
        for (int i = 0; i < 16; i++) put(8'(i), 1'b0);
        check("ovf.err4", 64'(err4), 1);
        check("ovf.wr_en4", 64'(wr_en4), 1);
        check("ovf.addr4", 64'(wr_addr4), 3);
        check("ovf.data4", 64'(wr_data4), 64'h0F0E0D0C);
        check("ovf.words4", 64'(words4), 4);
        for (int i = 16; i < 20; i++) begin
            put(8'(i), 1'b0);
            check($sformatf("ovf.s_ready4_byte%0d", i + 1), 64'(s_ready4), 0);
        end
        check("ovf.nwrites4", 64'(wq4.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf.log4_%0d", i), {wq4[i].a, wq4[i].d},
                  {32'(i), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        end
        check("ovf.hold4", 64'(hold4), 1);
        check("ovf.big_err", 64'(err), 0);
        check("ovf.big_words", 64'(words), 5);
        check("ovf.big_s_ready", 64'(s_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
